// File: rtl/sig_trace_writer_if.sv
`default_nettype none
// ============================================================================
//  Module      : sig_trace_writer_if
//  Description : Bundle of signals between the sample producers and the
//                display-memory trace writer: ECG/EMG/BPM valid/ready
//                channels, clear/busy control, write pointers and the
//                registered display-memory write port.
//                master : sample producer / memory side
//                slave  : sig_trace_writer
//  Revision    : 1.0  initial release
// ============================================================================
interface sig_trace_writer_if;
    logic        ecg_valid;
    logic [11:0] ecg_data;
    logic        ecg_ready;
    logic        emg_valid;
    logic [11:0] emg_data;
    logic        emg_ready;
    logic        bpm_valid;
    logic [15:0] bpm_data;
    logic        bpm_ready;
    logic        clear;
    logic        busy;
    logic [8:0]  ecg_wptr;
    logic [8:0]  emg_wptr;
    logic        mem_wen;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;

    modport master (
        output ecg_valid, ecg_data, emg_valid, emg_data,
               bpm_valid, bpm_data, clear,
        input  ecg_ready, emg_ready, bpm_ready, busy,
               ecg_wptr, emg_wptr, mem_wen, mem_addr, mem_wdata
    );

    modport slave (
        input  ecg_valid, ecg_data, emg_valid, emg_data,
               bpm_valid, bpm_data, clear,
        output ecg_ready, emg_ready, bpm_ready, busy,
               ecg_wptr, emg_wptr, mem_wen, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/sig_trace_writer.sv
`default_nettype none
// ============================================================================
//  Module      : sig_trace_writer
//  Description : Writer side of the display signal memory. ECG, EMG and BPM
//                samples arrive on valid/ready channels into one-word holding
//                slots; one slot per cycle is written to the 12-bit-address /
//                32-bit-data display memory. ECG and EMG use circular column
//                pointers with optional decimation; BPM is saturated and
//                written to a fixed word. A clear pulse zeroes both traces
//                and the BPM word with a one-word-per-cycle sweep.
//  Ports       : clock, reset      - system clock, synchronous active-high reset
//                bus (slave)       - sample channels, clear/busy, write
//                                    pointers and the registered write port
//  Revision    : 1.0  initial release
// ============================================================================
module sig_trace_writer #(
    parameter logic [11:0] ECG_BASE  = 12'h559,
    parameter logic [11:0] EMG_BASE  = 12'h6AD,
    parameter logic [11:0] BPM_ADDR  = 12'd1704,
    parameter int          TRACE_LEN = 335,
    parameter int          DECIM     = 1,
    parameter logic [15:0] BPM_MAX   = 16'd999
) (
    input  wire logic          clock,
    input  wire logic          reset,
    sig_trace_writer_if.slave  bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_K_W    = $clog2(2 * TRACE_LEN + 1);
    localparam int c_DCNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;

    localparam logic [8:0]          c_PTR_LAST  = 9'(TRACE_LEN - 1);
    localparam logic [8:0]          c_PTR_ONE   = 9'd1;
    localparam logic [c_K_W-1:0]    c_K_EMG     = c_K_W'(TRACE_LEN);
    localparam logic [c_K_W-1:0]    c_K_BPM     = c_K_W'(2 * TRACE_LEN);
    localparam logic [c_K_W-1:0]    c_K_ONE     = c_K_W'(1);
    localparam logic [c_DCNT_W-1:0] c_DCNT_LAST = c_DCNT_W'(DECIM - 1);
    localparam logic [c_DCNT_W-1:0] c_DCNT_ONE  = c_DCNT_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t              r_state;
    logic                r_busy;
    logic [c_K_W-1:0]    r_k;          // clear sweep word index

    logic                r_ecg_full, r_emg_full, r_bpm_full;
    logic [11:0]         r_ecg_hold, r_emg_hold;
    logic [15:0]         r_bpm_hold;
    logic [c_DCNT_W-1:0] r_ecg_dcnt, r_emg_dcnt;
    logic [8:0]          r_ecg_wptr, r_emg_wptr;
    logic                r_rr;         // 0: ECG wins an ECG/EMG tie, 1: EMG wins

    logic                r_mem_wen;
    logic [11:0]         r_mem_addr;
    logic [31:0]         r_mem_wdata;

    // ------------------------------------------------------------------------
    // Handshake and arbitration
    // ------------------------------------------------------------------------
    logic w_idle;
    logic w_ecg_ready, w_emg_ready, w_bpm_ready;
    logic w_ecg_xfer, w_emg_xfer, w_bpm_xfer;
    logic w_gnt_bpm, w_gnt_ecg, w_gnt_emg;

    assign w_idle      = (r_state == ST_IDLE);
    assign w_ecg_ready = w_idle & ~r_ecg_full & ~bus.clear;
    assign w_emg_ready = w_idle & ~r_emg_full & ~bus.clear;
    assign w_bpm_ready = w_idle & ~r_bpm_full & ~bus.clear;

    assign w_ecg_xfer  = bus.ecg_valid & w_ecg_ready;
    assign w_emg_xfer  = bus.emg_valid & w_emg_ready;
    assign w_bpm_xfer  = bus.bpm_valid & w_bpm_ready;

    // BPM has absolute priority; ECG/EMG alternate only when both are waiting.
    assign w_gnt_bpm = w_idle & r_bpm_full;
    assign w_gnt_ecg = w_idle & ~r_bpm_full & r_ecg_full & (~r_emg_full | ~r_rr);
    assign w_gnt_emg = w_idle & ~r_bpm_full & r_emg_full & (~r_ecg_full |  r_rr);

    // ------------------------------------------------------------------------
    // Write address / data sources
    // ------------------------------------------------------------------------
    logic [8:0]  w_ecg_wptr_nxt, w_emg_wptr_nxt;
    logic [11:0] w_ecg_addr, w_emg_addr;
    logic [15:0] w_bpm_sat;
    logic [11:0] w_sweep_addr;
    logic [11:0] w_k_ecg, w_k_emg;

    assign w_ecg_wptr_nxt = (r_ecg_wptr == c_PTR_LAST) ? 9'd0 : r_ecg_wptr + c_PTR_ONE;
    assign w_emg_wptr_nxt = (r_emg_wptr == c_PTR_LAST) ? 9'd0 : r_emg_wptr + c_PTR_ONE;
    assign w_ecg_addr     = ECG_BASE + {3'b000, r_ecg_wptr};
    assign w_emg_addr     = EMG_BASE + {3'b000, r_emg_wptr};
    assign w_bpm_sat      = (r_bpm_hold > BPM_MAX) ? BPM_MAX : r_bpm_hold;

    assign w_k_ecg = 12'(r_k);
    assign w_k_emg = 12'(r_k - c_K_EMG);

    // Sweep order: whole ECG trace, whole EMG trace, then the BPM word.
    always_comb begin
        w_sweep_addr = BPM_ADDR;
        if (r_k < c_K_EMG) begin
            w_sweep_addr = ECG_BASE + w_k_ecg;
        end else if (r_k < c_K_BPM) begin
            w_sweep_addr = EMG_BASE + w_k_emg;
        end
    end

    // ------------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_k         <= '0;
            r_ecg_full  <= 1'b0;
            r_emg_full  <= 1'b0;
            r_bpm_full  <= 1'b0;
            r_ecg_hold  <= '0;
            r_emg_hold  <= '0;
            r_bpm_hold  <= '0;
            r_ecg_dcnt  <= '0;
            r_emg_dcnt  <= '0;
            r_ecg_wptr  <= '0;
            r_emg_wptr  <= '0;
            r_rr        <= 1'b0;
            r_mem_wen   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else if (bus.clear) begin
            // Start (or restart) the sweep; anything still held is discarded.
            r_state    <= ST_CLEAR;
            r_busy     <= 1'b1;
            r_k        <= '0;
            r_ecg_full <= 1'b0;
            r_emg_full <= 1'b0;
            r_bpm_full <= 1'b0;
            r_ecg_dcnt <= '0;
            r_emg_dcnt <= '0;
            r_ecg_wptr <= '0;
            r_emg_wptr <= '0;
            r_rr       <= 1'b0;
            r_mem_wen  <= 1'b0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_mem_wen   <= 1'b1;
                    r_mem_addr  <= w_sweep_addr;
                    r_mem_wdata <= '0;
                    if (r_k == c_K_BPM) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_k <= r_k + c_K_ONE;
                    end
                end

                default: begin
                    // Intake: a slot is only marked full on the sample that
                    // completes a decimation period.
                    if (w_ecg_xfer) begin
                        if (r_ecg_dcnt == c_DCNT_LAST) begin
                            r_ecg_full <= 1'b1;
                            r_ecg_hold <= bus.ecg_data;
                            r_ecg_dcnt <= '0;
                        end else begin
                            r_ecg_dcnt <= r_ecg_dcnt + c_DCNT_ONE;
                        end
                    end
                    if (w_emg_xfer) begin
                        if (r_emg_dcnt == c_DCNT_LAST) begin
                            r_emg_full <= 1'b1;
                            r_emg_hold <= bus.emg_data;
                            r_emg_dcnt <= '0;
                        end else begin
                            r_emg_dcnt <= r_emg_dcnt + c_DCNT_ONE;
                        end
                    end
                    if (w_bpm_xfer) begin
                        r_bpm_full <= 1'b1;
                        r_bpm_hold <= bus.bpm_data;
                    end

                    // Write port: at most one grant per cycle. A granted slot
                    // is never also a transfer target (its ready was low).
                    r_mem_wen <= 1'b0;
                    if (w_gnt_bpm) begin
                        r_bpm_full  <= 1'b0;
                        r_mem_wen   <= 1'b1;
                        r_mem_addr  <= BPM_ADDR;
                        r_mem_wdata <= {16'b0, w_bpm_sat};
                    end else if (w_gnt_ecg) begin
                        r_ecg_full  <= 1'b0;
                        r_mem_wen   <= 1'b1;
                        r_mem_addr  <= w_ecg_addr;
                        r_mem_wdata <= {20'b0, r_ecg_hold};
                        r_ecg_wptr  <= w_ecg_wptr_nxt;
                        r_rr        <= ~r_rr;
                    end else if (w_gnt_emg) begin
                        r_emg_full  <= 1'b0;
                        r_mem_wen   <= 1'b1;
                        r_mem_addr  <= w_emg_addr;
                        r_mem_wdata <= {20'b0, r_emg_hold};
                        r_emg_wptr  <= w_emg_wptr_nxt;
                        r_rr        <= ~r_rr;
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.ecg_ready = w_ecg_ready;
    assign bus.emg_ready = w_emg_ready;
    assign bus.bpm_ready = w_bpm_ready;
    assign bus.busy      = r_busy;
    assign bus.ecg_wptr  = r_ecg_wptr;
    assign bus.emg_wptr  = r_emg_wptr;
    assign bus.mem_wen   = r_mem_wen;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_sig_trace_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sig_trace_writer
//  Description : Directed self-checking bench for sig_trace_writer. One
//                instance uses default parameters, a second uses DECIM=4.
//                Memory writes of each instance are logged at the falling
//                edge and compared against hand-computed values.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sig_trace_writer;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    sig_trace_writer_if if0 ();
    sig_trace_writer_if if4 ();

    sig_trace_writer u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (if0)
    );

    sig_trace_writer #(.DECIM(4)) u_dut4 (
        .clock (clock),
        .reset (reset),
        .bus   (if4)
    );

    typedef struct packed {
        logic [11:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t log0[$];
    wr_t log4[$];

    always @(negedge clock) begin
        if (if0.mem_wen === 1'b1) log0.push_back({if0.mem_addr, if0.mem_wdata});
        if (if4.mem_wen === 1'b1) log4.push_back({if4.mem_addr, if4.mem_wdata});
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        if0.ecg_valid = 1'b0; if0.ecg_data = '0;
        if0.emg_valid = 1'b0; if0.emg_data = '0;
        if0.bpm_valid = 1'b0; if0.bpm_data = '0;
        if0.clear     = 1'b0;
        if4.ecg_valid = 1'b0; if4.ecg_data = '0;
        if4.emg_valid = 1'b0; if4.emg_data = '0;
        if4.bpm_valid = 1'b0; if4.bpm_data = '0;
        if4.clear     = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        log0.delete();
        log4.delete();
    endtask

    // Offer one ECG sample on if0 and wait (bounded) for it to be taken.
    task automatic send_ecg(input logic [11:0] d);
        bit ok = 1'b0;
        if0.ecg_valid = 1'b1;
        if0.ecg_data  = d;
        for (int t = 0; t < 8; t++) begin
            if (if0.ecg_ready) begin
                ok = 1'b1;
                tick();
                break;
            end
            tick();
        end
        if0.ecg_valid = 1'b0;
        if (!ok) check("ecg_send_timeout", 32'd0, 32'd1);
    endtask

    // Expected address of sweep word k.
    function automatic logic [11:0] sweep_addr(input int k);
        if (k < 335)      return 12'(12'h559 + k);
        else if (k < 670) return 12'(12'h6AD + (k - 335));
        else              return 12'd1704;
    endfunction

    int n_busy;
    int n_bad;

    initial begin
        idle_inputs();
        do_reset();

        // ---------------- reset state ----------------
        check("rst_wen",   32'(if0.mem_wen),   32'd0);
        check("rst_addr",  32'(if0.mem_addr),  32'd0);
        check("rst_wdata", if0.mem_wdata,      32'd0);
        check("rst_busy",  32'(if0.busy),      32'd0);
        check("rst_wptr",  32'(if0.ecg_wptr),  32'd0);
        check("rst_ready", 32'({if0.ecg_ready, if0.emg_ready, if0.bpm_ready}), 32'h7);

        // ---------------- single ECG sample ----------------
        if0.ecg_valid = 1'b1;
        if0.ecg_data  = 12'hABC;
        tick();                       // transfer edge
        if0.ecg_valid = 1'b0;
        check("t1_ready_full", 32'(if0.ecg_ready), 32'd0);
        check("t1_wen_pre",    32'(if0.mem_wen),   32'd0);
        tick();                       // write edge
        check("t1_wen",   32'(if0.mem_wen),  32'd1);
        check("t1_addr",  32'(if0.mem_addr), 32'h559);
        check("t1_wdata", if0.mem_wdata,     32'h0000_0ABC);
        check("t1_wptr",  32'(if0.ecg_wptr), 32'd1);
        check("t1_ready", 32'(if0.ecg_ready), 32'd1);
        tick();
        check("t1_wen_drop",  32'(if0.mem_wen),  32'd0);
        check("t1_addr_hold", 32'(if0.mem_addr), 32'h559);

        // ---------------- pointer wrap ----------------
        do_reset();
        for (int i = 0; i < 336; i++) send_ecg(12'(i + 1));
        tick();
        tick();
        check("t2_count", 32'(log0.size()), 32'd336);
        if (log0.size() == 336) begin
            check("t2_first_addr", 32'(log0[0].addr),   32'h559);
            check("t2_335_addr",   32'(log0[334].addr), 32'h6A7);
            check("t2_335_data",   log0[334].data,      32'd335);
            check("t2_336_addr",   32'(log0[335].addr), 32'h559);
            check("t2_336_data",   log0[335].data,      32'd336);
        end
        check("t2_wptr", 32'(if0.ecg_wptr), 32'd1);

        // ---------------- BPM priority, saturation, ECG before EMG ----------------
        do_reset();
        if0.ecg_valid = 1'b1; if0.ecg_data = 12'h111;
        if0.emg_valid = 1'b1; if0.emg_data = 12'h222;
        if0.bpm_valid = 1'b1; if0.bpm_data = 16'd1200;
        tick();
        idle_inputs();
        for (int t = 0; t < 5; t++) tick();
        check("t3_count", 32'(log0.size()), 32'd3);
        if (log0.size() == 3) begin
            check("t3_bpm_addr", 32'(log0[0].addr), 32'd1704);
            check("t3_bpm_data", log0[0].data,      32'd999);
            check("t3_ecg_addr", 32'(log0[1].addr), 32'h559);
            check("t3_ecg_data", log0[1].data,      32'h111);
            check("t3_emg_addr", 32'(log0[2].addr), 32'h6AD);
            check("t3_emg_data", log0[2].data,      32'h222);
        end
        check("t3_ready", 32'({if0.ecg_ready, if0.emg_ready, if0.bpm_ready}), 32'h7);
        check("t3_emg_wptr", 32'(if0.emg_wptr), 32'd1);

        // ---------------- round-robin after an ECG grant ----------------
        do_reset();
        send_ecg(12'h101);
        tick();                       // ECG written, EMG now favoured
        if0.ecg_valid = 1'b1; if0.ecg_data = 12'h303;
        if0.emg_valid = 1'b1; if0.emg_data = 12'h202;
        tick();
        idle_inputs();
        for (int t = 0; t < 4; t++) tick();
        check("rr_count", 32'(log0.size()), 32'd3);
        if (log0.size() == 3) begin
            check("rr_first_emg_addr", 32'(log0[1].addr), 32'h6AD);
            check("rr_first_emg_data", log0[1].data,      32'h202);
            check("rr_then_ecg_addr",  32'(log0[2].addr), 32'h55A);
        end

        // ---------------- decimation (DECIM=4 instance) ----------------
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            bit ok = 1'b0;
            if4.ecg_valid = 1'b1;
            if4.ecg_data  = 12'(i);
            for (int t = 0; t < 8; t++) begin
                if (if4.ecg_ready) begin
                    ok = 1'b1;
                    tick();
                    break;
                end
                tick();
            end
            if4.ecg_valid = 1'b0;
            if (!ok) check("dec_send_timeout", 32'd0, 32'd1);
        end
        tick();
        tick();
        check("dec_count", 32'(log4.size()), 32'd2);
        if (log4.size() == 2) begin
            check("dec_w0_addr", 32'(log4[0].addr), 32'h559);
            check("dec_w0_data", log4[0].data,      32'd4);
            check("dec_w1_addr", 32'(log4[1].addr), 32'h55A);
            check("dec_w1_data", log4[1].data,      32'd8);
        end
        check("dec_wptr", 32'(if4.ecg_wptr), 32'd2);

        // ---------------- clear with a full ECG slot ----------------
        do_reset();
        if0.ecg_valid = 1'b1; if0.ecg_data = 12'h777;
        tick();                       // slot now full
        if0.ecg_valid = 1'b0;
        if0.clear     = 1'b1;
        tick();                       // clear wins over the pending grant
        if0.clear = 1'b0;
        check("clr_busy",  32'(if0.busy),      32'd1);
        check("clr_wen0",  32'(if0.mem_wen),   32'd0);
        check("clr_ready", 32'(if0.ecg_ready), 32'd0);
        n_busy = 0;
        while (if0.busy && n_busy < 2000) begin
            n_busy++;
            tick();
        end
        tick();
        check("clr_busy_cycles", 32'(n_busy), 32'd671);
        check("clr_count", 32'(log0.size()), 32'd671);
        if (log0.size() == 671) begin
            n_bad = 0;
            for (int k = 0; k < 671; k++) begin
                if (log0[k].addr !== sweep_addr(k) || log0[k].data !== 32'd0) n_bad++;
            end
            check("clr_sweep_words", 32'(n_bad), 32'd0);
            check("clr_w335_addr",   32'(log0[335].addr), 32'h6AD);
            check("clr_last_addr",   32'(log0[670].addr), 32'd1704);
        end
        for (int t = 0; t < 3; t++) tick();
        check("clr_slot_dropped", 32'(log0.size()), 32'd671);
        check("clr_ready_after",  32'(if0.ecg_ready), 32'd1);
        check("clr_wptr_after",   32'(if0.ecg_wptr),  32'd0);

        // ---------------- clear re-pulsed mid-sweep, then reset mid-sweep ----------------
        if0.clear = 1'b1;
        tick();
        if0.clear = 1'b0;
        for (int t = 0; t < 100; t++) tick();
        if0.clear = 1'b1;
        tick();
        if0.clear = 1'b0;
        log0.delete();
        for (int t = 0; t < 3; t++) tick();
        check("rep_restart_count", 32'(log0.size()), 32'd2);
        if (log0.size() >= 1) check("rep_restart_addr", 32'(log0[0].addr), 32'h559);
        check("rep_busy", 32'(if0.busy), 32'd1);
        for (int t = 0; t < 50; t++) tick();
        reset = 1'b1;
        tick();
        check("rst_mid_wen",  32'(if0.mem_wen),  32'd0);
        check("rst_mid_busy", 32'(if0.busy),     32'd0);
        check("rst_mid_addr", 32'(if0.mem_addr), 32'd0);
        reset = 1'b0;
        tick();
        check("rst_mid_ready", 32'(if0.ecg_ready), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
